// File: rtl/edge_frame_tx_packer.sv
// rtl/edge_frame_tx_packer.sv - binarize/pack edge pixels, buffer one frame, send AA 55 payload XOR to UART
module edge_frame_tx_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 80,
    parameter int IMG_HEIGHT = 120,
    parameter int BUF_ADDR_W = 11
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_de,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_clear,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_frame_sent,
    output logic                  o_overflow
);

    localparam int TOTAL  = IMG_WIDTH * IMG_HEIGHT;
    localparam int NBYTES = TOTAL / 8;
    localparam int DEPTH  = 2 ** BUF_ADDR_W;
    localparam int PIX_W  = $clog2(TOTAL);
    localparam int PAY_W  = $clog2(NBYTES + 1);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAY, CKS} state_t;

    state_t                state;
    logic [PIX_W-1:0]      pix_cnt;
    logic [2:0]            bit_cnt;
    logic [7:0]            pack_reg;
    logic [7:0]            mem [0:DEPTH-1];
    logic [BUF_ADDR_W-1:0] wr_ptr;
    logic [BUF_ADDR_W-1:0] rd_ptr;
    logic [BUF_ADDR_W:0]   count;
    logic [7:0]            rd_data;
    logic                  rd_pend;
    logic [PAY_W-1:0]      pay_cnt;
    logic [7:0]            cks;

    logic       pix_bit;
    logic [7:0] packed_byte;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       hs;
    logic       unused_pix_bits;

    // Only the pixel MSB carries the edge decision; new bits enter at the top so pixel j lands in bit j.
    assign pix_bit         = i_data[DATA_WIDTH-1];
    assign unused_pix_bits = ^i_data[DATA_WIDTH-2:0];
    assign packed_byte     = {pix_bit, pack_reg[7:1]};
    assign full            = (count == (BUF_ADDR_W+1)'(DEPTH));
    assign empty           = (count == '0);
    assign push            = i_de && !i_clear && (bit_cnt == 3'd7) && !full;
    assign pop             = (state == PAY) && !o_tx_valid && !rd_pend && !empty && !i_clear;
    assign hs              = o_tx_valid && i_tx_ready;
    assign o_busy          = (state != IDLE);

    // Byte buffer storage with a registered read port.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= packed_byte;
        if (pop)  rd_data     <= mem[rd_ptr];
    end

    // Pack side: shift pixel bits, count pixels per frame, flag writes into a full buffer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pack_reg   <= '0;
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            o_overflow <= 1'b0;
        end else if (i_clear) begin
            pack_reg   <= '0;
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            o_overflow <= 1'b0;
        end else if (i_de) begin
            pack_reg <= packed_byte;
            bit_cnt  <= bit_cnt + 3'd1;
            pix_cnt  <= (pix_cnt == PIX_W'(TOTAL - 1)) ? '0 : pix_cnt + 1'b1;
            if (bit_cnt == 3'd7 && full) o_overflow <= 1'b1;
        end
    end

    // Buffer pointers and occupancy; push and pop in the same cycle leave occupancy unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Send FSM: header, payload drained from the buffer, running XOR checksum; tx outputs registered here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            o_tx_data    <= '0;
            o_tx_valid   <= 1'b0;
            o_frame_sent <= 1'b0;
            rd_pend      <= 1'b0;
            pay_cnt      <= '0;
            cks          <= '0;
        end else if (i_clear) begin
            state        <= IDLE;
            o_tx_data    <= '0;
            o_tx_valid   <= 1'b0;
            o_frame_sent <= 1'b0;
            rd_pend      <= 1'b0;
            pay_cnt      <= '0;
            cks          <= '0;
        end else begin
            o_frame_sent <= 1'b0;
            rd_pend      <= pop;
            case (state)
                IDLE: begin
                    if (!empty || pix_cnt != '0) begin
                        state      <= HDR0;
                        o_tx_data  <= 8'hAA;
                        o_tx_valid <= 1'b1;
                    end
                end
                HDR0: begin
                    if (hs) begin
                        state     <= HDR1;
                        o_tx_data <= 8'h55;
                    end
                end
                HDR1: begin
                    if (hs) begin
                        state      <= PAY;
                        o_tx_valid <= 1'b0;
                    end
                end
                PAY: begin
                    if (rd_pend) begin
                        o_tx_data  <= rd_data;
                        o_tx_valid <= 1'b1;
                    end else if (hs) begin
                        cks <= cks ^ o_tx_data;
                        if (pay_cnt == PAY_W'(NBYTES - 1)) begin
                            state     <= CKS;
                            pay_cnt   <= '0;
                            o_tx_data <= cks ^ o_tx_data;
                        end else begin
                            pay_cnt    <= pay_cnt + 1'b1;
                            o_tx_valid <= 1'b0;
                        end
                    end
                end
                CKS: begin
                    if (hs) begin
                        state        <= IDLE;
                        o_tx_valid   <= 1'b0;
                        o_tx_data    <= '0;
                        o_frame_sent <= 1'b1;
                        cks          <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_frame_tx_packer.sv
// tb/tb_edge_frame_tx_packer.sv - self-checking bench for edge_frame_tx_packer
module tb_edge_frame_tx_packer;

    localparam int W     = 80;
    localparam int H     = 120;
    localparam int TOTAL = W * H;
    localparam int NB    = TOTAL / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rstn = 1'b1, a_de = 1'b0, a_clr = 1'b0, a_ready = 1'b0;
    logic [7:0] a_data = 8'h00, a_tx_data;
    logic       a_tx_valid, a_busy, a_fsent, a_ovf;
    logic       b_rstn = 1'b1, b_de = 1'b0, b_clr = 1'b0, b_ready = 1'b0;
    logic [7:0] b_data = 8'h00, b_tx_data;
    logic       b_tx_valid, b_busy, b_fsent, b_ovf;

    edge_frame_tx_packer #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .BUF_ADDR_W(11)) dut_a (
        .clk(clk), .rstn(a_rstn), .i_de(a_de), .i_data(a_data), .i_clear(a_clr),
        .o_tx_data(a_tx_data), .o_tx_valid(a_tx_valid), .i_tx_ready(a_ready),
        .o_busy(a_busy), .o_frame_sent(a_fsent), .o_overflow(a_ovf));

    edge_frame_tx_packer #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .BUF_ADDR_W(4)) dut_b (
        .clk(clk), .rstn(b_rstn), .i_de(b_de), .i_data(b_data), .i_clear(b_clr),
        .o_tx_data(b_tx_data), .o_tx_valid(b_tx_valid), .i_tx_ready(b_ready),
        .o_busy(b_busy), .o_frame_sent(b_fsent), .o_overflow(b_ovf));

    int total = 0;
    int bad   = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] rnd_pix [TOTAL];
    int         rdy_mode [2];
    int         fs_cnt [2];
    logic       exp_fs [2];
    logic       held [2];
    logic [7:0] held_data [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpush(input int d, input logic [8:0] v);
        if (d == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    // Pixel pattern for each test mode.
    function automatic logic [7:0] pix(input int mode, input int i);
        case (mode)
            0:       return (i % 2 == 0) ? 8'hFF : 8'h00;
            1:       return (i == 9) ? 8'hFF : (i == 10) ? 8'h80 : 8'h7F;
            default: return rnd_pix[i];
        endcase
    endfunction

    // Payload byte k gathers MSBs of pixels 8k..8k+7, pixel 8k+j into bit j.
    function automatic logic [7:0] model_byte(input int mode, input int k);
        logic [7:0] b;
        logic [7:0] p;
        b = '0;
        for (int j = 0; j < 8; j++) begin
            p    = pix(mode, 8 * k + j);
            b[j] = p[7];
        end
        return b;
    endfunction

    function automatic logic [7:0] model_cks(input int mode);
        logic [7:0] c;
        c = '0;
        for (int k = 0; k < NB; k++) c ^= model_byte(mode, k);
        return c;
    endfunction

    // Expected UART stream of one frame; bit 8 marks the checksum byte.
    task automatic build(input int d, input int mode);
        qpush(d, 9'h0AA);
        qpush(d, 9'h055);
        for (int k = 0; k < NB; k++) qpush(d, {1'b0, model_byte(mode, k)});
        qpush(d, {1'b1, model_cks(mode)});
    endtask

    task automatic drive(input int d, input logic v, input logic [7:0] x);
        if (d == 0) begin a_de = v; a_data = x; end
        else        begin b_de = v; b_data = x; end
    endtask

    task automatic send(input int d, input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive(d, 1'b1, pix(mode, i));
        end
    endtask

    task automatic idle(input int d);
        @(posedge clk); #1;
        drive(d, 1'b0, 8'h00);
    endtask

    task automatic drain(input int d, input string nm);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain_done"}, (qsize(d) == 0), 1);
        repeat (4) @(negedge clk);
    endtask

    // Ready generator: 0 = never, 1 = always, 2 = random stalls.
    initial begin
        forever begin
            @(posedge clk); #1;
            a_ready = (rdy_mode[0] == 2) ? ($urandom_range(0, 2) != 0) : (rdy_mode[0] == 1);
            b_ready = (rdy_mode[1] == 2) ? ($urandom_range(0, 2) != 0) : (rdy_mode[1] == 1);
        end
    end

    task automatic mon(input int d, input logic rn, input logic clr, input logic v, input logic r,
                       input logic [7:0] dat, input logic fs, input logic bsy, input logic ov);
        logic [8:0] e;
        if (!rn) begin
            chk("reset_outputs", {dat, v, fs, bsy, ov}, 0);
            held[d]   = 1'b0;
            exp_fs[d] = 1'b0;
            return;
        end
        chk("frame_sent", fs, exp_fs[d]);
        if (fs) fs_cnt[d]++;
        exp_fs[d] = 1'b0;
        if (held[d]) begin
            chk("hold_valid", v, 1);
            if (v) chk("hold_data", dat, held_data[d]);
        end
        held[d] = 1'b0;
        if (v && r && !clr) begin
            if (qsize(d) == 0) begin
                chk("unexpected_byte", {1'b1, dat}, 0);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk("tx_byte", dat, e[7:0]);
                if (e[8]) exp_fs[d] = 1'b1;
            end
        end else if (v && !clr) begin
            held[d]      = 1'b1;
            held_data[d] = dat;
        end
    endtask

    // Single compare process for both instances, sampled on the falling edge.
    always @(negedge clk) begin
        mon(0, a_rstn, a_clr, a_tx_valid, a_ready, a_tx_data, a_fsent, a_busy, a_ovf);
        mon(1, b_rstn, b_clr, b_tx_valid, b_ready, b_tx_data, b_fsent, b_busy, b_ovf);
    end

    initial begin
        #1500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        for (int i = 0; i < TOTAL; i++) rnd_pix[i] = 8'($urandom_range(0, 255));
        for (int d = 0; d < 2; d++) begin
            rdy_mode[d] = 0; fs_cnt[d] = 0; exp_fs[d] = 1'b0; held[d] = 1'b0; held_data[d] = '0;
        end

        chk("pin_alt_byte0", model_byte(0, 0), 8'h55);
        chk("pin_alt_last", model_byte(0, NB - 1), 8'h55);
        chk("pin_alt_cks", model_cks(0), 8'h00);
        chk("pin_t3_byte0", model_byte(1, 0), 8'h00);
        chk("pin_t3_byte1", model_byte(1, 1), 8'h06);
        chk("pin_t3_byte2", model_byte(1, 2), 8'h00);
        chk("pin_t3_cks", model_cks(1), 8'h06);

        // T1: reset with toggling input, then quiet release
        #1;
        a_rstn = 1'b0; b_rstn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(0, ~a_de, 8'hFF);
            drive(1, ~b_de, 8'hFF);
        end
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        @(posedge clk); #1;
        a_rstn = 1'b1; b_rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("t1_busy_a", a_busy, 0);
        chk("t1_busy_b", b_busy, 0);
        chk("t1_valid_a", a_tx_valid, 0);

        // T2: alternating pixels, always ready
        rdy_mode[0] = 1;
        f0 = fs_cnt[0];
        build(0, 0);
        send(0, 0, TOTAL);
        idle(0);
        drain(0, "t2");
        chk("t2_frames", fs_cnt[0] - f0, 1);
        chk("t2_busy", a_busy, 0);

        // T3: sparse pattern, only MSB counts
        f0 = fs_cnt[0];
        build(0, 1);
        send(0, 1, TOTAL);
        idle(0);
        drain(0, "t3");
        chk("t3_frames", fs_cnt[0] - f0, 1);

        // T4: T2 frame with random ready stalls
        rdy_mode[0] = 2;
        f0 = fs_cnt[0];
        build(0, 0);
        send(0, 0, TOTAL);
        idle(0);
        drain(0, "t4");
        chk("t4_frames", fs_cnt[0] - f0, 1);
        rdy_mode[0] = 1;

        // T5: two frames back to back
        f0 = fs_cnt[0];
        build(0, 2);
        build(0, 0);
        send(0, 2, TOTAL);
        send(0, 0, TOTAL);
        idle(0);
        drain(0, "t5");
        chk("t5_frames", fs_cnt[0] - f0, 2);
        chk("t5_overflow", a_ovf, 0);

        // T6: tiny buffer, UART stalled -> overflow; clear; fresh frame
        rdy_mode[1] = 0;
        send(1, 0, 400);
        idle(1);
        @(negedge clk);
        chk("t6_overflow_set", b_ovf, 1);
        chk("t6_busy_pre", b_busy, 1);
        @(posedge clk); #1;
        b_clr = 1'b1;
        @(posedge clk); #1;
        b_clr = 1'b0;
        @(negedge clk);
        chk("t6_overflow_clr", b_ovf, 0);
        chk("t6_busy_clr", b_busy, 0);
        chk("t6_valid_clr", b_tx_valid, 0);
        rdy_mode[1] = 1;
        f0 = fs_cnt[1];
        build(1, 1);
        send(1, 1, TOTAL);
        idle(1);
        drain(1, "t6");
        chk("t6_frames", fs_cnt[1] - f0, 1);
        chk("t6_overflow_end", b_ovf, 0);

        // T7: reset mid-payload, then a fresh frame
        build(0, 0);
        send(0, 0, 2000);
        @(posedge clk); #1;
        a_rstn = 1'b0;
        drive(0, 1'b0, 8'h00);
        q0.delete();
        #1;
        chk("t7_valid_rst", a_tx_valid, 0);
        chk("t7_busy_rst", a_busy, 0);
        repeat (3) @(posedge clk);
        #1;
        a_rstn = 1'b1;
        f0 = fs_cnt[0];
        build(0, 1);
        send(0, 1, TOTAL);
        idle(0);
        drain(0, "t7");
        chk("t7_frames", fs_cnt[0] - f0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
